// File: rtl/decoder_scan.sv
// Registered active-low one-hot select driver with direct, timed-pulse and rotating-scan modes.
// All outputs update one cycle after the sampled inputs; strobes during a pulse are dropped, never queued.
module decoder_scan #(
  parameter int SEL_W = 5,
  parameter int OUT_N = 32,
  parameter int DWELL = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEna,
  input  logic [1:0]       iMode,
  input  logic [SEL_W-1:0] iData,
  input  logic             iStb,
  output logic [OUT_N-1:0] oData,
  output logic [SEL_W-1:0] oIdx,
  output logic             oBusy,
  output logic             oErr
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] M_DIRECT = 2'b00;
  localparam logic [1:0] M_PULSE  = 2'b01;
  localparam logic [1:0] M_SCAN   = 2'b10;

  typedef enum logic [1:0] {IDLE, DIRECT, PULSE, SCAN} state_t;

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_N-1:0] r_data;
  logic [SEL_W-1:0] r_idx;
  logic             r_busy;
  logic             r_err;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [OUT_N-1:0] w_data_nxt;
  logic [SEL_W-1:0] w_idx_nxt;
  logic             w_busy_nxt;
  logic             w_err_nxt;
  logic             w_in_range;
  logic             w_dwell_done;
  logic [SEL_W-1:0] w_scan_next;

  function automatic logic [OUT_N-1:0] f_sel(input logic [SEL_W-1:0] idx);
    return ~(OUT_N'(1) << idx);
  endfunction

  // One extra bit so OUT_N == 2**SEL_W is representable in the unsigned compare.
  assign w_in_range   = {1'b0, iData} < (SEL_W+1)'(OUT_N);
  assign w_dwell_done = (r_cnt == CNT_W'(DWELL-1));
  assign w_scan_next  = ({1'b0, r_idx} == (SEL_W+1)'(OUT_N-1)) ? '0 : r_idx + SEL_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = '1;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    if (iMode != r_mode) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else if (!iEna) begin
      // Scan keeps index and dwell count so rotation resumes where it paused.
      if (r_state == PULSE) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    end else begin
      case (iMode)
        M_DIRECT: begin
          w_state_nxt = DIRECT;
          if (w_in_range) begin
            w_data_nxt = f_sel(iData);
            w_idx_nxt  = iData;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        M_PULSE: begin
          if (r_state == PULSE) begin
            if (w_dwell_done) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt  = r_cnt + CNT_W'(1);
              w_data_nxt = f_sel(r_idx);
              w_busy_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = IDLE;
            if (iStb && w_in_range) begin
              w_state_nxt = PULSE;
              w_cnt_nxt   = '0;
              w_idx_nxt   = iData;
              w_data_nxt  = f_sel(iData);
              w_busy_nxt  = 1'b1;
            end else if (iStb) begin
              w_err_nxt = 1'b1;
            end
          end
        end
        M_SCAN: begin
          w_busy_nxt = 1'b1;
          if (r_state != SCAN) begin
            w_state_nxt = SCAN;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_data_nxt  = f_sel('0);
          end else if (w_dwell_done) begin
            w_cnt_nxt  = '0;
            w_idx_nxt  = w_scan_next;
            w_data_nxt = f_sel(w_scan_next);
          end else begin
            w_cnt_nxt  = r_cnt + CNT_W'(1);
            w_data_nxt = f_sel(r_idx);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state <= IDLE;
      r_mode  <= M_DIRECT;
      r_cnt   <= '0;
      r_data  <= '1;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= iMode;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign oData = r_data;
  assign oIdx  = r_idx;
  assign oBusy = r_busy;
  assign oErr  = r_err;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: three instances (32/4, 20/2, 4/2 lines/dwell) share one stimulus bus.
module tb_decoder_scan;

  typedef struct {
    logic        rn;
    logic        en;
    logic [1:0]  md;
    logic [4:0]  d;
    logic        s;
    int          dut;
    logic [31:0] ed;
    logic [4:0]  ei;
    logic        eb;
    logic        ee;
    bit          ci;
    string       nm;
  } vec_t;

  localparam logic [31:0] ONE = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        t_rst_n = 1'b0;
  logic        t_ena = 1'b0;
  logic [1:0]  t_mode = 2'b00;
  logic [4:0]  t_data = '0;
  logic        t_stb = 1'b0;

  logic [31:0] a_data;
  logic [4:0]  a_idx;
  logic        a_busy, a_err;
  logic [19:0] b_data;
  logic [4:0]  b_idx;
  logic        b_busy, b_err;
  logic [3:0]  c_data;
  logic [1:0]  c_idx;
  logic        c_busy, c_err;

  int n_chk = 0;
  int n_pass = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  decoder_scan u_a (
    .iClk(clk), .iRst_n(t_rst_n), .iEna(t_ena), .iMode(t_mode), .iData(t_data), .iStb(t_stb),
    .oData(a_data), .oIdx(a_idx), .oBusy(a_busy), .oErr(a_err)
  );

  decoder_scan #(.SEL_W(5), .OUT_N(20), .DWELL(2)) u_b (
    .iClk(clk), .iRst_n(t_rst_n), .iEna(t_ena), .iMode(t_mode), .iData(t_data), .iStb(t_stb),
    .oData(b_data), .oIdx(b_idx), .oBusy(b_busy), .oErr(b_err)
  );

  decoder_scan #(.SEL_W(2), .OUT_N(4), .DWELL(2)) u_c (
    .iClk(clk), .iRst_n(t_rst_n), .iEna(t_ena), .iMode(t_mode), .iData(t_data[1:0]), .iStb(t_stb),
    .oData(c_data), .oIdx(c_idx), .oBusy(c_busy), .oErr(c_err)
  );

  function automatic logic [31:0] lo(input int k);
    logic [31:0] one;
    one = 32'd1;
    return ~(one << k);
  endfunction

  function automatic vec_t mk(input logic rn, en, input logic [1:0] md, input logic [4:0] d,
                              input logic s, input int dut, input logic [31:0] ed,
                              input logic [4:0] ei, input logic eb, ee, input bit ci, input string nm);
    vec_t v;
    v.rn = rn; v.en = en; v.md = md; v.d = d; v.s = s; v.dut = dut;
    v.ed = ed; v.ei = ei; v.eb = eb; v.ee = ee; v.ci = ci; v.nm = nm;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then compare once the DUT has registered it.
  task automatic step(input vec_t v);
    vec_t r;
    logic [31:0] ad;
    logic [4:0]  ai;
    logic        ab, ae;
    @(negedge clk);
    t_rst_n = v.rn; t_ena = v.en; t_mode = v.md; t_data = v.d; t_stb = v.s;
    sb.push_back(v);
    @(posedge clk);
    #1;
    r = sb.pop_front();
    if (r.dut >= 0) begin
      case (r.dut)
        0:       begin ad = a_data;                ai = a_idx;          ab = a_busy; ae = a_err; end
        1:       begin ad = {12'hFFF, b_data};     ai = b_idx;          ab = b_busy; ae = b_err; end
        default: begin ad = {28'hFFF_FFFF, c_data}; ai = {3'b000, c_idx}; ab = c_busy; ae = c_err; end
      endcase
      n_chk++;
      if (ad === r.ed && ab === r.eb && ae === r.ee && (!r.ci || ai === r.ei)) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got oData=%h oIdx=%0d oBusy=%b oErr=%b, expected oData=%h oIdx=%0d oBusy=%b oErr=%b",
                 r.nm, ad, ai, ab, ae, r.ed, r.ei, r.eb, r.ee);
      end
    end
  endtask

  initial begin
    int ks[4];

    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 2'b00, 0, 0, i, ONE, 0, 0, 0, 1, "reset"));
    tbl.push_back(mk(1, 1, 2'b00, 5,  0, 0, lo(5),  5,  0, 0, 1, "dir5"));
    tbl.push_back(mk(1, 1, 2'b00, 31, 0, 0, 32'h7FFF_FFFF, 31, 0, 0, 1, "dir31"));
    tbl.push_back(mk(1, 1, 2'b00, 25, 0, 1, ONE,    0,  0, 1, 0, "oor25"));
    tbl.push_back(mk(1, 1, 2'b00, 7,  0, 1, lo(7),  7,  0, 0, 1, "oor_clear"));
    tbl.push_back(mk(1, 1, 2'b00, 19, 0, 1, lo(19), 19, 0, 0, 1, "dir19_top"));
    tbl.push_back(mk(1, 1, 2'b00, 20, 0, 1, ONE,    0,  0, 1, 0, "oor20"));
    tbl.push_back(mk(1, 0, 2'b00, 3,  0, 0, ONE,    0,  0, 0, 0, "dir_disabled"));
    tbl.push_back(mk(1, 1, 2'b00, 0,  0, 0, lo(0),  0,  0, 0, 1, "dir0"));
    tbl.push_back(mk(1, 1, 2'b01, 20, 0, 0, ONE,    0,  0, 0, 0, "mode_chg_pulse"));
    tbl.push_back(mk(1, 1, 2'b01, 20, 1, 1, ONE,    0,  0, 1, 0, "pulse_oor_err"));
    tbl.push_back(mk(1, 1, 2'b01, 20, 0, 1, ONE,    0,  0, 0, 0, "pulse_oor_clear"));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 2'b01, 0, 0, -1, ONE, 0, 0, 0, 0, "settle"));
    tbl.push_back(mk(1, 1, 2'b01, 3, 1, 0, lo(3), 3, 1, 0, 1, "pulse_c0"));
    tbl.push_back(mk(1, 1, 2'b01, 3, 0, 0, lo(3), 3, 1, 0, 1, "pulse_c1"));
    tbl.push_back(mk(1, 1, 2'b01, 9, 1, 0, lo(3), 3, 1, 0, 1, "pulse_restrobe"));
    tbl.push_back(mk(1, 1, 2'b01, 9, 0, 0, lo(3), 3, 1, 0, 1, "pulse_c3"));
    tbl.push_back(mk(1, 1, 2'b01, 9, 0, 0, ONE,   0, 0, 0, 0, "pulse_end"));
    tbl.push_back(mk(1, 1, 2'b01, 9, 0, 0, ONE,   0, 0, 0, 0, "pulse_idle"));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Held strobe: the line must go high for one cycle before the next pulse starts.
    for (int i = 0; i < 6; i++)
      step(mk(1, 1, 2'b01, 2, 1, 0, (i == 4) ? ONE : lo(2), 2, (i != 4), 0, (i != 4), "pulse_b2b"));

    // Abort mid-pulse by dropping enable; FSM must be idle and accept a fresh strobe.
    step(mk(1, 0, 2'b01, 2, 0, 0, ONE,   0, 0, 0, 0, "pulse_abort"));
    step(mk(1, 1, 2'b01, 2, 0, 0, ONE,   0, 0, 0, 0, "abort_no_resume"));
    step(mk(1, 1, 2'b01, 7, 1, 0, lo(7), 7, 1, 0, 1, "abort_restart"));
    step(mk(0, 1, 2'b01, 7, 0, 0, ONE,   0, 0, 0, 1, "reset_mid_pulse"));
    step(mk(1, 1, 2'b01, 7, 0, 0, ONE,   0, 0, 0, 1, "after_reset"));

    // Scan on 4 lines with dwell 2.
    step(mk(1, 1, 2'b10, 0, 0, 2, ONE, 0, 0, 0, 0, "mode_chg_scan"));
    for (int i = 0; i < 13; i++)
      step(mk(1, 1, 2'b10, 0, 0, 2, lo((i / 2) % 4), 5'((i / 2) % 4), 1, 0, 1, "scan_seq"));
    for (int i = 0; i < 3; i++)
      step(mk(1, 0, 2'b10, 0, 0, 2, ONE, 2, 0, 0, 1, "scan_pause"));
    ks = '{2, 3, 3, 0};
    for (int i = 0; i < 4; i++)
      step(mk(1, 1, 2'b10, 0, 0, 2, lo(ks[i]), 5'(ks[i]), 1, 0, 1, "scan_resume"));

    step(mk(1, 1, 2'b00, 5, 0, 0, ONE,   0, 0, 0, 0, "scan_to_dir_gap"));
    step(mk(1, 1, 2'b00, 5, 0, 0, lo(5), 5, 0, 0, 1, "scan_to_dir"));
    step(mk(1, 1, 2'b11, 5, 0, 0, ONE,   0, 0, 0, 0, "mode_chg_rsvd"));
    step(mk(1, 1, 2'b11, 5, 1, 0, ONE,   0, 0, 0, 0, "reserved_mode"));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
